rr_burst_arbiter: RTL and testbench

//  N-way round-robin arbiter that hands a shared resource to one requester at a time.

---
 rtl/rr_burst_arbiter.sv | 157 +++++++++++++++
 tb/tb_rr_burst_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rr_burst_arbiter
//
// N-way round-robin arbiter for one shared resource. One requester owns the
// resource at a time. A burst lasts at most MAX_BURST cycles, and at least one
// idle turnaround cycle always follows it. The owner that releases gets the
// lowest priority in the next pick.
//
// Parameters
//   N          number of requesters (>= 2)
//   MAX_BURST  maximum consecutive grant cycles for one owner (>= 1)
//   ID_W       width of o_gnt_id    (derived, do not override)
//   CNT_W      width of o_burst_cnt (derived, do not override)
//
// Ports
//   i_clock      clock, all logic on the rising edge
//   i_reset      synchronous active-low reset (0 = reset)
//   i_arb_en     1 = new grants allowed; an ongoing burst is never cut short
//   i_req        level-sensitive request vector, bit i = requester i
//   o_gnt        registered grant, all zero or one-hot
//   o_gnt_id     index of the current owner; keeps the last owner while idle
//   o_busy       1 while o_gnt != 0
//   o_burst_cnt  cycles granted so far in this burst (1..MAX_BURST), 0 when idle
// -----------------------------------------------------------------------------
module rr_burst_arbiter #(
   parameter int N         = 4,
   parameter int MAX_BURST = 8,
   parameter int ID_W      = $clog2(N),
   parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_arb_en,
   input  logic [N-1:0]     i_req,
   output logic [N-1:0]     o_gnt,
   output logic [ID_W-1:0]  o_gnt_id,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_burst_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_TURN = 2'd2
   } state_t;

   state_t            r_state;
   logic [N-1:0]      r_gnt;
   logic [ID_W-1:0]   r_gnt_id;
   logic [CNT_W-1:0]  r_cnt;
   logic [ID_W-1:0]   r_ptr;

   state_t            w_state_nxt;
   logic [N-1:0]      w_gnt_nxt;
   logic [ID_W-1:0]   w_gnt_id_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [ID_W-1:0]   w_ptr_nxt;

   logic              w_pick_vld;
   logic [ID_W-1:0]   w_pick_id;
   logic              w_release;

   localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);

   // Round-robin pick: among the active requests, choose the one whose
   // distance from the priority pointer (walking upward, wrapping at N) is
   // smallest. Distance-based selection keeps this correct for any N, not
   // only powers of two.
   always_comb begin
      int v_best;
      int v_dist;
      v_best     = N;
      v_dist     = 0;
      w_pick_vld = 1'b0;
      w_pick_id  = '0;
      for (int i = 0; i < N; i++) begin
         v_dist = (i - int'(r_ptr) + N) % N;
         if (i_req[i] && (v_dist < v_best)) begin
            v_best     = v_dist;
            w_pick_vld = 1'b1;
            w_pick_id  = ID_W'(i);
         end
      end
   end

   // The burst ends when the owner lets go of its request or when it has
   // already had MAX_BURST cycles; both in the same cycle still give one
   // release.
   assign w_release = !i_req[r_gnt_id] || (r_cnt == CNT_MAX);

   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      w_cnt_nxt    = r_cnt;
      w_ptr_nxt    = r_ptr;

      case (r_state)
         // IDLE and TURN arbitrate identically. TURN exists only so that a
         // released grant is always followed by at least one zero cycle.
         ST_IDLE, ST_TURN: begin
            if (i_arb_en && w_pick_vld) begin
               w_state_nxt  = ST_BUSY;
               w_gnt_nxt    = ONE_HOT0 << w_pick_id;
               w_gnt_id_nxt = w_pick_id;
               w_cnt_nxt    = CNT_W'(1);
            end else begin
               w_state_nxt  = ST_IDLE;
               w_gnt_nxt    = '0;
               w_cnt_nxt    = '0;
            end
         end

         // Other requesters and i_arb_en are ignored while a burst runs.
         ST_BUSY: begin
            if (w_release) begin
               w_state_nxt = ST_TURN;
               w_gnt_nxt   = '0;
               w_cnt_nxt   = '0;
               // The releasing owner moves to the back of the queue.
               w_ptr_nxt   = (r_gnt_id == ID_W'(N - 1)) ? '0 : r_gnt_id + ID_W'(1);
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state  <= ST_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_cnt    <= '0;
         r_ptr    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ptr    <= w_ptr_nxt;
      end
   end

   assign o_gnt       = r_gnt;
   assign o_gnt_id    = r_gnt_id;
   assign o_busy      = |r_gnt;
   assign o_burst_cnt = r_cnt;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for rr_burst_arbiter. Two instances share the same stimulus: one with
// MAX_BURST=4 and one with MAX_BURST=1. A driver applies inputs on the falling
// edge, advances a behavioural model of the arbiter and queues the outputs
// expected after the next rising edge. A monitor samples the DUTs just after
// each rising edge and compares them with the queued entries.
// -----------------------------------------------------------------------------
module tb_rr_burst_arbiter;

   localparam int N   = 4;
   localparam int MB0 = 4;
   localparam int MB1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          arb_en;
   logic [N-1:0]  req;

   logic [N-1:0]  gnt0, gnt1;
   logic [1:0]    id0, id1;
   logic          busy0, busy1;
   logic [2:0]    cnt0;
   logic [0:0]    cnt1;

   rr_burst_arbiter #(.N(N), .MAX_BURST(MB0)) u_dut0 (
      .i_clock(clk), .i_reset(rst_n), .i_arb_en(arb_en), .i_req(req),
      .o_gnt(gnt0), .o_gnt_id(id0), .o_busy(busy0), .o_burst_cnt(cnt0)
   );

   rr_burst_arbiter #(.N(N), .MAX_BURST(MB1)) u_dut1 (
      .i_clock(clk), .i_reset(rst_n), .i_arb_en(arb_en), .i_req(req),
      .o_gnt(gnt1), .o_gnt_id(id1), .o_busy(busy1), .o_burst_cnt(cnt1)
   );

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic [3:0] cnt;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource (-1 = nobody), how long they
   // have held it, where the round-robin search starts and the last owner.
   int m_owner[2];
   int m_len[2];
   int m_ptr[2];
   int m_last[2];
   int m_max[2];

   task automatic model_step(input int u, input logic rn, input logic en,
                             input logic [N-1:0] rq, output exp_t e);
      if (!rn) begin
         m_owner[u] = -1;
         m_len[u]   = 0;
         m_ptr[u]   = 0;
         m_last[u]  = 0;
      end else if (m_owner[u] >= 0) begin
         if (!rq[m_owner[u]] || m_len[u] == m_max[u]) begin
            m_ptr[u]   = (m_owner[u] + 1) % N;
            m_owner[u] = -1;
            m_len[u]   = 0;
         end else begin
            m_len[u]   = m_len[u] + 1;
         end
      end else if (en && rq != '0) begin
         for (int off = 0; off < N; off++) begin
            int idx;
            idx = (m_ptr[u] + off) % N;
            if (rq[idx]) begin
               m_owner[u] = idx;
               m_last[u]  = idx;
               m_len[u]   = 1;
               break;
            end
         end
      end
      e.gnt  = (m_owner[u] >= 0) ? 4'(1 << m_owner[u]) : 4'b0000;
      e.id   = 2'(m_last[u]);
      e.busy = (m_owner[u] >= 0);
      e.cnt  = 4'(m_len[u]);
   endtask

   task automatic drive(input logic rn, input logic en, input logic [N-1:0] rq);
      exp_t e;
      @(negedge clk);
      rst_n  = rn;
      arb_en = en;
      req    = rq;
      model_step(0, rn, en, rq, e);
      q0.push_back(e);
      model_step(1, rn, en, rq, e);
      q1.push_back(e);
   endtask

   task automatic chk(input string nm, input int u, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got %0h expected %0h", nm, u, $time, act, exp);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("gnt",       0, int'(gnt0),  int'(e.gnt));
            chk("gnt_id",    0, int'(id0),   int'(e.id));
            chk("busy",      0, int'(busy0), int'(e.busy));
            chk("burst_cnt", 0, int'(cnt0),  int'(e.cnt));
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("gnt",       1, int'(gnt1),  int'(e.gnt));
            chk("gnt_id",    1, int'(id1),   int'(e.id));
            chk("busy",      1, int'(busy1), int'(e.busy));
            chk("burst_cnt", 1, int'(cnt1),  int'(e.cnt));
         end
      end
   end

   // Stimulus
   initial begin
      logic [N-1:0] mask;
      logic [N-1:0] rq;
      m_max[0] = MB0;
      m_max[1] = MB1;
      for (int u = 0; u < 2; u++) begin
         m_owner[u] = -1;
         m_len[u]   = 0;
         m_ptr[u]   = 0;
         m_last[u]  = 0;
      end
      rst_n  = 1'b0;
      arb_en = 1'b1;
      req    = 4'b1111;

      // Reset held with all requests active, then all requesting continuously.
      repeat (2)  drive(1'b0, 1'b1, 4'b1111);
      repeat (24) drive(1'b1, 1'b1, 4'b1111);

      // Two requesters alternating full bursts.
      drive(1'b0, 1'b1, 4'b0000);
      repeat (14) drive(1'b1, 1'b1, 4'b0011);

      // Single requester dropping its request.
      drive(1'b0, 1'b1, 4'b0000);
      repeat (3) drive(1'b1, 1'b1, 4'b0001);
      repeat (4) drive(1'b1, 1'b1, 4'b0000);

      // Arbitration disabled, then enabled, then disabled mid-burst.
      repeat (5) drive(1'b1, 1'b0, 4'b0100);
      repeat (3) drive(1'b1, 1'b1, 4'b0100);
      repeat (5) drive(1'b1, 1'b0, 4'b0100);
      repeat (2) drive(1'b1, 1'b0, 4'b0000);

      // Reset in the middle of a burst of owner 2, then requester 3 alone.
      drive(1'b0, 1'b1, 4'b0000);
      repeat (2) drive(1'b1, 1'b1, 4'b0100);
      drive(1'b0, 1'b1, 4'b0100);
      repeat (3) drive(1'b1, 1'b1, 4'b1000);

      // Every owner drops its request right after it is granted.
      drive(1'b0, 1'b1, 4'b0000);
      mask = 4'b1111;
      repeat (20) begin
         if (m_owner[0] >= 0) mask[m_owner[0]] = 1'b0;
         drive(1'b1, 1'b1, mask);
      end

      // Randomized traffic: requests held for a few cycles at a time,
      // occasional arb_en low and rare resets.
      rq = 4'($urandom);
      repeat (800) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
         drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0), rq);
      end

      repeat (3) @(posedge clk);
      #2;
      chk("queue_drain", 0, q0.size(), 0);
      chk("queue_drain", 1, q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
